btn_debounce: RTL
=================

Name: btn_debounce

Overview:
Input-conditioning stage that sits directly upstream of the Simon game core and drives its btn[3:0] input.
- Synchronises raw pushbutton pins into clk, optionally inverts them, and debounces each button on a millisecond time base derived from ticks_per_milli.
- Emits clean levels plus single-cycle press/release pulses.
- The game core therefore sees only glitch-free, debounced button states.

Parameters:
NUM_BTN, 4, number of buttons handled (independent channels)
DEBOUNCE_MS, 10, milliseconds an input must hold a new value before btn changes (legal range 1..255)
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal range 2..3)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
ticks_per_milli  input  16  clk cycles per millisecond (same value the game core receives)
btn_raw  input  NUM_BTN  asynchronous button pins
btn_active_low  input  1  1: a pressed button reads 0 on btn_raw; 0: a pressed button reads 1
btn  output  NUM_BTN  debounced level, 1 = pressed, registered
btn_press  output  NUM_BTN  one-cycle pulse on each debounced 0->1, registered
btn_release  output  NUM_BTN  one-cycle pulse on each debounced 1->0, registered
btn_any  output  1  OR of btn (combinational from the btn register)

Behaviour:
- One clock only; every register updates on posedge clk. Reset is synchronous, active-low, and has priority over all other logic.
- Reset values:
  - btn, btn_press, btn_release = 0; btn_any = 0.
  - Synchroniser stages = 0 (released); debounce counters = 0; milli prescaler = 0.
- Polarity: norm = btn_raw XOR {NUM_BTN{btn_active_low}}, applied before the synchroniser. A change of btn_active_low at runtime is treated like any other input change and is debounced.
- Synchroniser: SYNC_STAGES flops per bit. The last stage is sync[i].
- Milli prescaler:
  - 16-bit counter, shared by all channels.
  - When the counter == ticks_per_milli-1: milli_tick pulses for one cycle and the counter returns to 0. Otherwise the counter increments.
  - ticks_per_milli of 0 or 1: milli_tick is asserted every cycle.
  - If ticks_per_milli drops below the current count, the counter wraps through 0xFFFF normally. No special handling.
- Per-channel debounce (independent per i), with an 8-bit counter cnt[i]:
  - sync[i] == btn[i]: cnt[i] <= 0. Any bounce restarts the hold window.
  - sync[i] != btn[i] and no milli_tick: cnt[i] holds.
  - sync[i] != btn[i] and milli_tick:
    - If cnt[i] == DEBOUNCE_MS-1: btn[i] <= sync[i], cnt[i] <= 0, and the matching press/release pulse is asserted in the same cycle btn[i] changes.
    - Else cnt[i] <= cnt[i]+1.
- Latency: btn[i] changes on the DEBOUNCE_MS-th milli_tick observed while the mismatch is continuously present. From the btn_raw edge this is SYNC_STAGES cycles plus between (DEBOUNCE_MS-1) and DEBOUNCE_MS milliseconds, depending on prescaler phase.
- Pulses:
  - btn_press[i] and btn_release[i] are high for exactly one cycle and are never high together.
  - They are 0 in every cycle in which btn[i] does not change.
- Simultaneous events: channels are fully independent. Several buttons may flip in the same cycle; their pulses assert together.
- Reset mid-operation: pending counts are discarded. A button held through reset is reported as a fresh press DEBOUNCE_MS ms after rst_n deasserts.
- No internal state beyond the synchronisers, the prescaler, cnt[] and btn[].

Test Plan:
1. ticks_per_milli=4, DEBOUNCE_MS=10, btn_active_low=0: drive btn_raw[2]=1 and hold -> btn=4'b0100 after 2 + 37..40 cycles; btn_press=4'b0100 for exactly 1 cycle; btn_any=1.
2. Bounce: toggle btn_raw[0] every 12 cycles (3 ms) for 100 cycles, then hold 1 -> btn[0] stays 0 during the toggling; it rises only 10 ms (≈40 cycles) after the final edge; exactly one btn_press[0] pulse.
3. Release: from btn=4'b0001, drop btn_raw[0] to 0 -> btn_release[0] pulses once after ≈40 cycles, btn=0, btn_any=0; btn_press stays 0 throughout.
4. Polarity: btn_active_low=1 with btn_raw=4'b1111 from reset -> btn stays 0; then btn_raw=4'b0111 -> btn=4'b1000 after debounce.
5. Simultaneous: btn_raw 0000->1001 in one cycle -> btn=1001 and btn_press=1001 in the same cycle. Also assert rst_n=0 for 1 cycle mid-count on a third button -> all outputs 0 next cycle, and that button is re-debounced from zero.
6. ticks_per_milli=0 and =1: press held -> btn rises SYNC_STAGES+DEBOUNCE_MS cycles after the edge; no X or lockup.

Source files
------------

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: polarity fix, synchroniser, millisecond-based debounce
// and registered press/release pulses for each button channel.
module btn_debounce #(
  parameter int NUM_BTN     = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        ticks_per_milli,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               btn_active_low,
  output logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               btn_any
);

  localparam logic [7:0] HOLD_LAST = 8'(DEBOUNCE_MS - 1);

  logic [NUM_BTN-1:0]                    norm;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0]   sync_q;
  logic [NUM_BTN-1:0]                    sync_last;

  logic [15:0]                           milli_cnt_q, milli_cnt_d;
  logic                                  milli_tick;

  logic [NUM_BTN-1:0][7:0]               cnt_q, cnt_d;
  logic [NUM_BTN-1:0]                    btn_q, btn_d;
  logic [NUM_BTN-1:0]                    press_q, press_d;
  logic [NUM_BTN-1:0]                    release_q, release_d;

  // Polarity is folded in ahead of the synchroniser so a runtime flip is debounced too.
  assign norm      = btn_raw ^ {NUM_BTN{btn_active_low}};
  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= norm;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_comb begin
    milli_tick  = (ticks_per_milli <= 16'd1) ||
                  (milli_cnt_q == (ticks_per_milli - 16'd1));
    milli_cnt_d = milli_tick ? 16'd0 : (milli_cnt_q + 16'd1);
  end

  always_comb begin
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync_last[i] == btn_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (milli_tick) begin
        if (cnt_q[i] == HOLD_LAST) begin
          btn_d[i]     = sync_last[i];
          press_d[i]   = sync_last[i];
          release_d[i] = ~sync_last[i];
          cnt_d[i]     = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      milli_cnt_q <= 16'd0;
      cnt_q       <= '0;
      btn_q       <= '0;
      press_q     <= '0;
      release_q   <= '0;
    end else begin
      milli_cnt_q <= milli_cnt_d;
      cnt_q       <= cnt_d;
      btn_q       <= btn_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign btn         = btn_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_any     = |btn_q;

endmodule
